// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
//   Shared definitions for the two-port FIFO read arbiter.
//   - arb_state_t       : arbiter FSM state encoding
//   - BURST_MAX_DEFAULT : default maximum consecutive pops per grant
//   - CNT_W             : width of the burst counter
//   - gnt_state()       : maps a port index to its grant state
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int BURST_MAX_DEFAULT = 4;
    localparam int CNT_W             = 4;

    function automatic arb_state_t gnt_state(input logic port);
        return port ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/mux_arbiter_2x1_burst_counter.sv
// burst_counter
//   Counts pops within one grant. Clear has priority over increment, and the
//   count saturates at LIMIT so it can never wrap.
//   Ports:
//     clk      - clock
//     reset    - asynchronous active-high reset
//     clear    - zero the count (grant entry / re-grant)
//     inc      - one pop happened this cycle
//     at_limit - count equals LIMIT (the next pop is the last of the burst)
module burst_counter
    import mux_arb_pkg::*;
#(
    parameter int LIMIT = BURST_MAX_DEFAULT - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_reg;

    assign at_limit = (count_reg == LIMIT_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && !at_limit) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mux_arbiter_2x1.sv
// mux_arbiter_2x1
//   Round-robin burst arbiter draining two show-ahead FIFOs into one
//   registered output stream. A port keeps the grant for up to BURST_MAX
//   pops, then the other port gets its turn if it has data.
//   Ports:
//     clk, reset        - clock, asynchronous active-high reset
//     In0, In1          - FIFO head data (valid while matching empty is low)
//     empty0, empty1    - FIFO empty flags
//     down_afull        - downstream almost-full, stalls all pops
//     pop0, pop1        - combinational read strobes, mutually exclusive
//     mux_sel           - registered current grant
//     data_out          - registered popped word
//     outValid          - one-cycle pulse per popped word
module mux_arbiter_2x1
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = BURST_MAX_DEFAULT   // legal 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] In0,
    input  logic [DATA_W-1:0] In1,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              down_afull,
    output logic              pop0,
    output logic              pop1,
    output logic              mux_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              outValid
);

    arb_state_t        state_reg, state_next;
    logic              last_gnt_reg, last_gnt_next;
    logic              mux_sel_reg, mux_sel_next;
    // Set for one cycle after a limit-driven hand-over so the new port's
    // first cycle is a bubble, matching the bubble of an empty-driven switch.
    logic              bubble_reg, bubble_next;
    logic [DATA_W-1:0] data_out_reg;
    logic              out_valid_reg;

    logic              cnt_clear;
    logic              cnt_inc;
    logic              at_limit;
    logic              cur;
    logic              pop_any;
    logic [1:0]        empty_vec;
    logic [1:0]        pop_vec;

    assign empty_vec = {empty1, empty0};

    burst_counter #(
        .LIMIT(BURST_MAX - 1)
    ) u_burst_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        mux_sel_next  = mux_sel_reg;
        bubble_next   = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
        cur           = 1'b0;
        pop_any       = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                // Arbitration waits while downstream is almost full.
                if (!down_afull) begin
                    if (!empty0 && !empty1) begin
                        state_next   = gnt_state(~last_gnt_reg);
                        mux_sel_next = ~last_gnt_reg;
                    end else if (!empty0) begin
                        state_next   = GNT0;
                        mux_sel_next = 1'b0;
                    end else if (!empty1) begin
                        state_next   = GNT1;
                        mux_sel_next = 1'b1;
                    end
                end
            end

            GNT0, GNT1: begin
                cur     = (state_reg == GNT1);
                pop_any = !empty_vec[cur] && !down_afull && !bubble_reg && !reset;
                if (empty_vec[cur] || (pop_any && at_limit)) begin
                    last_gnt_next = cur;
                    cnt_clear     = 1'b1;
                    if (!empty_vec[~cur]) begin
                        state_next   = gnt_state(~cur);
                        mux_sel_next = ~cur;
                        bubble_next  = pop_any;
                    end else if (empty_vec[cur]) begin
                        state_next = IDLE;
                    end
                    // else: same port still has data, re-grant with a fresh count
                end else begin
                    cnt_inc = pop_any;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-port strobe: only the currently granted port can pop.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pop
        assign pop_vec[gi] = pop_any && (cur == gi[0]);
    end

    assign pop0 = pop_vec[0];
    assign pop1 = pop_vec[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_gnt_reg  <= 1'b1;
            mux_sel_reg   <= 1'b0;
            bubble_reg    <= 1'b0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_gnt_reg  <= last_gnt_next;
            mux_sel_reg   <= mux_sel_next;
            bubble_reg    <= bubble_next;
            out_valid_reg <= pop_any;
            if (pop_any) begin
                data_out_reg <= pop_vec[1] ? In1 : In0;
            end
        end
    end

    assign mux_sel  = mux_sel_reg;
    assign data_out = data_out_reg;
    assign outValid = out_valid_reg;

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// tb_mux_arbiter_2x1
//   Drives two queue-backed FIFOs into the arbiter and compares every cycle
//   against a grant/burst reference model, plus directed burst scenarios and
//   a randomized traffic run.
module tb_mux_arbiter_2x1;

    localparam int DW = 8;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0, in1;
    logic          empty0, empty1, down_afull;
    logic          pop0, pop1, mux_sel, out_valid;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    mux_arbiter_2x1 #(.DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk        (clk),
        .reset      (reset),
        .In0        (in0),
        .In1        (in1),
        .empty0     (empty0),
        .empty1     (empty1),
        .down_afull (down_afull),
        .pop0       (pop0),
        .pop1       (pop1),
        .mux_sel    (mux_sel),
        .data_out   (data_out),
        .outValid   (out_valid)
    );

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] out_log[$];
    int            out_cyc[$];

    int checks = 0;
    int errors = 0;

    // reference model: who owns the grant, pops served in this burst,
    // who held it last, and whether the next cycle is a hand-over bubble
    int            owner;
    int            served;
    int            last;
    bit            bubble;
    logic [DW-1:0] exp_data;
    logic          exp_sel;
    int            cycle;
    int            words;
    int            wait_pops[2];
    int            max_wait;
    logic          seen_pop0, seen_pop1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        served   = 0;
        last     = 1;
        bubble   = 0;
        exp_data = '0;
        exp_sel  = 1'b0;
        cycle    = 0;
        wait_pops[0] = 0;
        wait_pops[1] = 0;
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        empty0     = 1'b0;
        empty1     = 1'b0;
        down_afull = 1'b0;
        #1;
        check("rst_pop0", pop0, 0);
        check("rst_pop1", pop1, 0);
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_sel", mux_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive FIFO heads, check pops, advance the model,
    // then check the registered outputs after the edge.
    task automatic step(input bit afull);
        bit            e[2];
        int            p;
        int            i;
        bit            nb;
        logic [DW-1:0] d;
        down_afull = afull;
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
        in0 = empty0 ? DW'($urandom) : q0[0];
        in1 = empty1 ? DW'($urandom) : q1[0];
        e[0] = empty0;
        e[1] = empty1;
        #1;
        p = -1;
        if (owner >= 0 && !bubble && !e[owner] && !afull) p = owner;
        check("pop0", pop0, p == 0);
        check("pop1", pop1, p == 1);
        check("pop_excl", pop0 & pop1, 0);
        seen_pop0 = pop0;
        seen_pop1 = pop1;

        for (int k = 0; k < 2; k++) begin
            if (e[k] || p == k) wait_pops[k] = 0;
            else if (p == 1 - k) wait_pops[k]++;
            if (wait_pops[k] > max_wait) max_wait = wait_pops[k];
        end

        nb = 0;
        if (owner < 0) begin
            if (!afull) begin
                if (!e[0] && !e[1]) owner = 1 - last;
                else if (!e[0]) owner = 0;
                else if (!e[1]) owner = 1;
                if (owner >= 0) exp_sel = owner[0];
                served = 0;
            end
        end else begin
            i = owner;
            if (e[i] || (p >= 0 && served == BM - 1)) begin
                last   = i;
                served = 0;
                if (!e[1 - i]) begin
                    owner   = 1 - i;
                    exp_sel = owner[0];
                    nb      = (p >= 0);
                end else if (e[i]) begin
                    owner = -1;
                end
            end else if (p >= 0) begin
                served++;
            end
        end
        bubble = nb;

        @(posedge clk);
        #1;
        cycle++;
        if (p >= 0) begin
            d = (p == 0) ? q0.pop_front() : q1.pop_front();
            exp_data = d;
            out_log.push_back(d);
            out_cyc.push_back(cycle);
            words++;
            $display("cycle %0d port %0d data %02h", cycle, p, d);
        end
        check("out_valid", out_valid, p >= 0);
        check("data_out", data_out, exp_data);
        check("mux_sel", mux_sel, exp_sel);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 300 && !(q0.size() == 0 && q1.size() == 0 && owner < 0)) begin
            step(0);
            n++;
        end
        check({"drain_", tag}, (q0.size() == 0 && q1.size() == 0 && owner < 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp30[12];
        int n;
        exp30 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h04, 8'h05, 8'h07, 8'h08};
        in0 = '0;
        in1 = '0;
        words = 0;
        max_wait = 0;
        @(negedge clk);
        do_reset();

        // two-port round robin with BURST_MAX=4
        for (int k = 0; k <= 5; k++) q0.push_back(DW'(k));
        for (int k = 3; k <= 8; k++) q1.push_back(DW'(k));
        drain("rr");
        check("rr_len", out_log.size(), 12);
        for (int k = 0; k < 12 && k < out_log.size(); k++) check("rr_word", out_log[k], exp30[k]);
        if (out_cyc.size() == 12) begin
            check("rr_bubble1", out_cyc[4] - out_cyc[3], 2);
            check("rr_bubble2", out_cyc[8] - out_cyc[7], 2);
            check("rr_bubble3", out_cyc[10] - out_cyc[9], 2);
        end

        // single port, 10 words, back-to-back
        do_reset();
        for (int k = 0; k < 10; k++) q1.push_back(DW'(8'h10 + k));
        drain("solo");
        check("solo_len", out_log.size(), 10);
        if (out_cyc.size() == 10) check("solo_span", out_cyc[9] - out_cyc[0], 9);

        // downstream stall for 3 cycles mid-burst
        do_reset();
        for (int k = 0; k < 8; k++) q0.push_back(DW'(8'h20 + k));
        step(0); step(0); step(0);
        step(1); step(1); step(1);
        drain("afull");
        check("afull_len", out_log.size(), 8);
        if (out_cyc.size() == 8) check("afull_gap", out_cyc[2] - out_cyc[1], 4);
        for (int k = 0; k < out_log.size(); k++) check("afull_word", out_log[k], DW'(8'h20 + k));

        // FIFO0 runs dry after 2 words -> hand over to port 1
        do_reset();
        q0.push_back(8'h30); q0.push_back(8'h31);
        q1.push_back(8'h38); q1.push_back(8'h39); q1.push_back(8'h3a);
        step(0); step(0); step(0); step(0);
        check("dry_sel", mux_sel, 1);
        drain("dry");
        check("dry_len", out_log.size(), 5);
        if (out_log.size() == 5) begin
            check("dry_w1", out_log[1], 8'h31);
            check("dry_w2", out_log[2], 8'h38);
        end

        // asynchronous reset during the 2nd pop of a port-1 burst
        do_reset();
        for (int k = 0; k < 6; k++) q1.push_back(DW'(8'h50 + k));
        step(0); step(0);
        empty0 = 1'b1; empty1 = 1'b0; in1 = q1[0]; down_afull = 1'b0;
        #1;
        check("ar_pop1_pre", pop1, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_pop1", pop1, 0);
        check("ar_pop0", pop0, 0);
        check("ar_valid", out_valid, 0);
        check("ar_data", data_out, 0);
        check("ar_sel", mux_sel, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) q0.push_back(DW'(8'h40 + k));
        step(0); step(0);
        check("ar_first_pop0", seen_pop0, 1);
        check("ar_first_pop1", seen_pop1, 0);
        drain("ar");

        // random traffic
        do_reset();
        words = 0;
        max_wait = 0;
        n = 0;
        while (n < 20000 && words < 1000) begin
            if ($urandom_range(0, 99) < 45 && q0.size() < 12) q0.push_back(DW'($urandom));
            if ($urandom_range(0, 99) < 40 && q1.size() < 12) q1.push_back(DW'($urandom));
            step($urandom_range(0, 4) == 0);
            n++;
        end
        check("rand_words", words >= 1000, 1);
        drain("rand");
        check("rand_fair", max_wait <= BM + 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_2x1.md
MUX_ARBITER_2X1 -- requirements
Module: mux_arbiter_2x1

Interface
REQ-001 Parameter DATA_W, default 8: width of both data inputs and data_out.
REQ-002 Parameter BURST_MAX, default 4, legal range 1..15: maximum consecutive pops granted to one port before re-arbitration.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 In0, In1  input  DATA_W  show-ahead read data of upstream FIFOs 0/1; valid whenever the matching empty flag is low.
REQ-006 empty0, empty1  input  1  upstream FIFO empty flags.
REQ-007 down_afull  input  1  downstream almost-full; high blocks all pops.
REQ-008 pop0, pop1  output  1  combinational read strobes to FIFO 0/1; never both high.
REQ-009 mux_sel  output  1  registered; current grant (0=port 0, 1=port 1).
REQ-010 data_out  output  DATA_W  registered selected data.
REQ-011 outValid  output  1  registered; high for exactly one cycle per accepted word.

Function
REQ-012 FSM states IDLE, GNT0, GNT1; a last_gnt register records the most recently granted port.
REQ-013 IDLE: both non-empty -> grant port != last_gnt; one non-empty -> grant it; none -> stay IDLE.
REQ-014 GNTi: popi = !emptyi && !down_afull; the other pop stays 0.
REQ-015 Burst counter: 0 on grant entry; +1 on each popi; saturating compare at BURST_MAX-1.
REQ-016 GNTi exits when emptyi=1, or when a pop occurs with counter = BURST_MAX-1.
REQ-017 Exit target: other port non-empty -> GNTj, last_gnt=i; else port i still non-empty -> GNTi with counter cleared; else IDLE.
REQ-018 down_afull=1 freezes the state, counter and mux_sel. No exit is evaluated except for emptyi=1.
REQ-019 mux_sel updates on the same edge as the state transition. In IDLE it holds its last value.
REQ-020 On a cycle with popi=1, next edge: data_out <= Ini, outValid <= 1. Latency is 1 cycle from pop to outValid.
REQ-021 Without a pop: outValid <= 0 and data_out holds.
REQ-022 emptyi dropping to 1 in the same cycle as the last legal pop: no pop occurs that cycle, the exit of REQ-016 applies, and no word is lost or duplicated.
REQ-023 Throughput: one word per cycle while the granted FIFO is non-empty and down_afull=0. The switch cycle between ports produces no pop (one bubble).
REQ-024 The counter width is 4 bits. No arithmetic wraps within the legal BURST_MAX range.

Reset
REQ-025 reset=1 forces, asynchronously: state=IDLE, last_gnt=1 (so port 0 wins the first tie), counter=0, mux_sel=0, data_out=0, outValid=0.
REQ-026 pop0 and pop1 are 0 while reset=1.
REQ-027 Reset asserted mid-burst discards the grant. The first arbitration after release follows REQ-013 with last_gnt=1.

Structure
REQ-028 Shared package mux_arb_pkg holds the state enum (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the BURST_MAX default.
REQ-029 One sub-module, burst_counter (clear, inc, limit compare -> at_limit), is instantiated once. All other logic is flat.

Verification
REQ-030 FIFO0 holds 0x00..0x05, FIFO1 holds 0x03..0x08, BURST_MAX=4 -> output 00,01,02,03, then 03,04,05,06, then 04,05, then 07,08. One bubble at each switch.
REQ-031 Only FIFO1 holds 10 words -> 10 consecutive outValid pulses, data in order, mux_sel=1 throughout, the counter restarting every 4 pops.
REQ-032 down_afull pulsed high for 3 cycles mid-burst -> pops stop on the next cycle, no outValid for 3 cycles, the burst resumes with the counter unchanged, and no word is lost.
REQ-033 reset pulsed during the 2nd pop of a port-1 burst -> all outputs are 0 immediately. After release with both FIFOs non-empty, port 0 is granted first.
REQ-034 FIFO0 goes empty after 2 words while FIFO1 is non-empty -> switch to GNT1 on the next edge and last_gnt=0.
REQ-035 A random-traffic run of 1000 words -> output sequence per port matches the input order, pop0&pop1 is never asserted, and no port waits more than BURST_MAX+1 pops while non-empty.
